// File: rtl/player_hazard_monitor.sv
// Player-versus-obstacle hazard monitor: per-frame overlap test and the death/fade/respawn/grace sequence.
// Optional feature macro GOD_MODE_EN adds a God_Mode input that suppresses new deaths while ALIVE.
module player_hazard_monitor #(
    parameter int NUM_CIRCLES  = 4,
    parameter int FADE_FRAMES  = 30,
    parameter int GRACE_FRAMES = 60
) (
    input  logic                     Reset,
    input  logic                     frame_clk,
`ifdef GOD_MODE_EN
    input  logic                     God_Mode,
`endif
    input  logic [9:0]               PlayerX,
    input  logic [9:0]               PlayerY,
    input  logic [9:0]               PlayerS,
    input  logic [10*NUM_CIRCLES-1:0] Circle_X,
    input  logic [10*NUM_CIRCLES-1:0] Circle_Y,
    input  logic [10*NUM_CIRCLES-1:0] Circle_S,
    input  logic [NUM_CIRCLES-1:0]   Circle_En,
    output logic                     Respawn,
    output logic                     Dead,
    output logic                     Invuln,
    output logic [3:0]               Fade_Level,
    output logic [2:0]               Hit_Index,
    output logic [15:0]              Death_Count
);

    typedef enum logic [1:0] {ALIVE, DYING, RESPAWN, GRACE} state_t;

    localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        respawn_q, respawn_d;
    logic        dead_q, dead_d;
    logic        invuln_q, invuln_d;
    logic [3:0]  fade_q, fade_d;
    logic [2:0]  hit_idx_q, hit_idx_d;
    logic [15:0] death_cnt_q, death_cnt_d;

    logic [NUM_CIRCLES-1:0] hit_vec;
    logic                   hit_any;
    logic [2:0]             hit_idx;

    // Unsigned distances (larger minus smaller) against an 11-bit reach so nothing wraps.
    for (genvar gi = 0; gi < NUM_CIRCLES; gi++) begin : g_hit
        logic [9:0]  cx, cy, cs, dx, dy;
        logic [10:0] reach;
        assign cx    = Circle_X[10*gi +: 10];
        assign cy    = Circle_Y[10*gi +: 10];
        assign cs    = Circle_S[10*gi +: 10];
        assign dx    = (PlayerX >= cx) ? (PlayerX - cx) : (cx - PlayerX);
        assign dy    = (PlayerY >= cy) ? (PlayerY - cy) : (cy - PlayerY);
        assign reach = {1'b0, PlayerS} + {1'b0, cs};
        assign hit_vec[gi] = Circle_En[gi] && ({1'b0, dx} <= reach) && ({1'b0, dy} <= reach);
    end

`ifdef GOD_MODE_EN
    assign hit_any = (|hit_vec) && !God_Mode;
`else
    assign hit_any = |hit_vec;
`endif

    always_comb begin
        hit_idx = 3'd0;
        for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = 3'(i);
        end
    end

    function automatic logic [3:0] fade_of(input logic [7:0] c);
        logic [11:0] q;
        q = ({4'b0, c} << 4) / 12'(FADE_FRAMES);
        return (q > 12'd15) ? 4'd15 : q[3:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_idx_d   = hit_idx_q;
        death_cnt_d = death_cnt_q;
        respawn_d   = 1'b0;
        dead_d      = 1'b0;
        invuln_d    = 1'b0;
        fade_d      = 4'd0;

        case (state_q)
            ALIVE: begin
                if (hit_any) begin
                    state_d   = DYING;
                    cnt_d     = 8'd0;
                    hit_idx_d = hit_idx;
                    if (death_cnt_q != 16'hFFFF) death_cnt_d = death_cnt_q + 16'd1;
                end
            end
            DYING: begin
                if (cnt_q == FADE_LAST) state_d = RESPAWN;
                else                    cnt_d   = cnt_q + 8'd1;
            end
            RESPAWN: begin
                cnt_d   = 8'd0;
                state_d = (GRACE_FRAMES == 0) ? ALIVE : GRACE;
            end
            GRACE: begin
                if (cnt_q == GRACE_LAST) begin
                    state_d = ALIVE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ALIVE;
        endcase

        // Outputs are decoded from the next state so the registers show the post-edge state.
        case (state_d)
            DYING: begin
                dead_d = 1'b1;
                fade_d = fade_of(cnt_d);
            end
            RESPAWN: begin
                respawn_d = 1'b1;
                fade_d    = 4'd15;
            end
            GRACE:   invuln_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ALIVE;
            cnt_q       <= 8'd0;
            respawn_q   <= 1'b0;
            dead_q      <= 1'b0;
            invuln_q    <= 1'b0;
            fade_q      <= 4'd0;
            hit_idx_q   <= 3'd0;
            death_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            respawn_q   <= respawn_d;
            dead_q      <= dead_d;
            invuln_q    <= invuln_d;
            fade_q      <= fade_d;
            hit_idx_q   <= hit_idx_d;
            death_cnt_q <= death_cnt_d;
        end
    end

    assign Respawn     = respawn_q;
    assign Dead        = dead_q;
    assign Invuln      = invuln_q;
    assign Fade_Level  = fade_q;
    assign Hit_Index   = hit_idx_q;
    assign Death_Count = death_cnt_q;

endmodule

// File: tb/tb_player_hazard_monitor.sv
// Directed bench for player_hazard_monitor with default parameters (4 obstacles, 30 fade, 60 grace).
module tb_player_hazard_monitor;
    localparam int N = 4;

    logic            Reset;
    logic            frame_clk;
    logic            God_Mode;
    logic [9:0]      PlayerX, PlayerY, PlayerS;
    logic [10*N-1:0] Circle_X, Circle_Y, Circle_S;
    logic [N-1:0]    Circle_En;
    logic            Respawn, Dead, Invuln;
    logic [3:0]      Fade_Level;
    logic [2:0]      Hit_Index;
    logic [15:0]     Death_Count;

    int checks = 0;
    int passed = 0;

    player_hazard_monitor #(.NUM_CIRCLES(N), .FADE_FRAMES(30), .GRACE_FRAMES(60)) dut (
        .Reset(Reset),
        .frame_clk(frame_clk),
`ifdef GOD_MODE_EN
        .God_Mode(God_Mode),
`endif
        .PlayerX(PlayerX),
        .PlayerY(PlayerY),
        .PlayerS(PlayerS),
        .Circle_X(Circle_X),
        .Circle_Y(Circle_Y),
        .Circle_S(Circle_S),
        .Circle_En(Circle_En),
        .Respawn(Respawn),
        .Dead(Dead),
        .Invuln(Invuln),
        .Fade_Level(Fade_Level),
        .Hit_Index(Hit_Index),
        .Death_Count(Death_Count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic set_circle(input int i, input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
        Circle_X[10*i +: 10] = x;
        Circle_Y[10*i +: 10] = y;
        Circle_S[10*i +: 10] = s;
    endtask

    initial begin
        int exp_fade;
        Reset     = 1'b1;
        God_Mode  = 1'b0;
        PlayerX   = 10'd100;
        PlayerY   = 10'd100;
        PlayerS   = 10'd4;
        Circle_X  = '0;
        Circle_Y  = '0;
        Circle_S  = '0;
        Circle_En = '0;
        repeat (2) @(negedge frame_clk);
        check("rst_respawn", 32'(Respawn), 0);
        check("rst_dead", 32'(Dead), 0);
        check("rst_invuln", 32'(Invuln), 0);
        check("rst_fade", 32'(Fade_Level), 0);
        check("rst_hitidx", 32'(Hit_Index), 0);
        check("rst_count", 32'(Death_Count), 0);
        Reset = 1'b0;
        tick();
        check("idle_dead", 32'(Dead), 0);

        // Near miss: dx=8 > reach 7
        set_circle(0, 10'd108, 10'd100, 10'd3);
        Circle_En = 4'b0001;
        tick();
        check("miss_dead", 32'(Dead), 0);
        check("miss_count", 32'(Death_Count), 0);

        // Touching: dx=7 == reach 7, held through the whole sequence
        set_circle(0, 10'd107, 10'd100, 10'd3);
        tick();
        $display("frame 1: Dead=%0d Count=%0d Idx=%0d Fade=%0d", Dead, Death_Count, Hit_Index, Fade_Level);
        check("hit_dead", 32'(Dead), 1);
        check("hit_count", 32'(Death_Count), 1);
        check("hit_idx", 32'(Hit_Index), 0);
        check("hit_fade0", 32'(Fade_Level), 0);
        check("hit_respawn", 32'(Respawn), 0);
        for (int f = 2; f <= 30; f++) begin
            tick();
            exp_fade = ((f - 1) * 16) / 30;
            if (exp_fade > 15) exp_fade = 15;
            check("dying_dead", 32'(Dead), 1);
            check("dying_fade", 32'(Fade_Level), 32'(exp_fade));
        end
        check("fade_final", 32'(Fade_Level), 15);
        tick();
        $display("frame 31: Respawn=%0d Dead=%0d Fade=%0d", Respawn, Dead, Fade_Level);
        check("respawn_pulse", 32'(Respawn), 1);
        check("respawn_dead", 32'(Dead), 0);
        check("respawn_fade", 32'(Fade_Level), 15);
        for (int f = 32; f <= 91; f++) begin
            tick();
            check("grace_invuln", 32'(Invuln), 1);
            check("grace_respawn", 32'(Respawn), 0);
            check("grace_fade", 32'(Fade_Level), 0);
            check("grace_count", 32'(Death_Count), 1);
        end
        tick();
        $display("frame 92: Invuln=%0d Dead=%0d Count=%0d", Invuln, Dead, Death_Count);
        check("alive_invuln", 32'(Invuln), 0);
        check("alive_dead", 32'(Dead), 0);
        check("alive_count", 32'(Death_Count), 1);
        tick();
        $display("frame 93: Dead=%0d Count=%0d", Dead, Death_Count);
        check("redeath_dead", 32'(Dead), 1);
        check("redeath_count", 32'(Death_Count), 2);

        // Asynchronous reset with counter at 10 in DYING
        repeat (10) tick();
        #1 Reset = 1'b1;
        #1;
        $display("mid-dying reset: Dead=%0d Count=%0d", Dead, Death_Count);
        check("arst_dead", 32'(Dead), 0);
        check("arst_count", 32'(Death_Count), 0);
        check("arst_fade", 32'(Fade_Level), 0);
        check("arst_invuln", 32'(Invuln), 0);
        @(negedge frame_clk);
        Reset     = 1'b0;
        Circle_En = 4'b0000;
        tick();
        check("post_rst_dead", 32'(Dead), 0);
        check("post_rst_count", 32'(Death_Count), 0);

        // Obstacles 1 and 3 overlap; 0 overlaps but is disabled; 2 is far away
        set_circle(0, 10'd100, 10'd100, 10'd5);
        set_circle(1, 10'd103, 10'd98, 10'd2);
        set_circle(2, 10'd300, 10'd300, 10'd2);
        set_circle(3, 10'd96, 10'd104, 10'd1);
        Circle_En = 4'b1110;
        tick();
        $display("multi hit: Dead=%0d Count=%0d Idx=%0d", Dead, Death_Count, Hit_Index);
        check("multi_dead", 32'(Dead), 1);
        check("multi_count", 32'(Death_Count), 1);
        check("multi_idx", 32'(Hit_Index), 1);
        Circle_En = 4'b0000;
        repeat (91) tick();
        check("multi_done_dead", 32'(Dead), 0);
        check("multi_done_invuln", 32'(Invuln), 0);

        // Saturation: preload the counter to FFFE
        force dut.death_cnt_q = 16'hFFFE;
        #1 release dut.death_cnt_q;
        @(negedge frame_clk);
        check("preload_count", 32'(Death_Count), 32'hFFFE);
        set_circle(2, 10'd100, 10'd100, 10'd0);
        Circle_En = 4'b0100;
        tick();
        $display("sat death 1: Count=%0h Idx=%0d", Death_Count, Hit_Index);
        check("sat1_count", 32'(Death_Count), 32'hFFFF);
        check("sat1_idx", 32'(Hit_Index), 2);
        Circle_En = 4'b0000;
        repeat (91) tick();
        Circle_En = 4'b0100;
        tick();
        $display("sat death 2: Dead=%0d Count=%0h", Dead, Death_Count);
        check("sat2_dead", 32'(Dead), 1);
        check("sat2_count", 32'(Death_Count), 32'hFFFF);
        Circle_En = 4'b0000;
        repeat (91) tick();
        check("sat_done_dead", 32'(Dead), 0);

`ifdef GOD_MODE_EN
        God_Mode  = 1'b1;
        Circle_En = 4'b0100;
        tick();
        $display("god mode: Dead=%0d Count=%0h", Dead, Death_Count);
        check("god_dead", 32'(Dead), 0);
        check("god_count", 32'(Death_Count), 32'hFFFF);
        God_Mode  = 1'b0;
        Circle_En = 4'b0000;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
